alu_share_arbiter: RTL

//  Shares the single 32-bit ALU between NUM_REQ requesters (EX stage, address-gen, CSR/debug) using round-robin.

---
 rtl/alu_share_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU among NUM_REQ requesters with a tagged one-entry response register; optional perf counters under ALU_ARB_PERF_EN
module alu_share_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]  req_ctrl,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
`ifdef ALU_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0] perf_grant_cnt,
  output logic [15:0]           perf_stall_cnt,
`endif
  output logic                  rsp_zero
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            can_issue, gnt;
  logic [ID_W-1:0] gnt_idx, cand;
  assign can_issue = !rsp_valid_q || rsp_ready;
  // Round-robin search starting just after the last granted requester
  always_comb begin
    gnt = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt && req_valid[cand]) begin
        gnt = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = gnt && can_issue;
  end
  // Grant fan-out to requesters and ALU operand mux
  always_comb begin
    req_ready = gnt ? NUM_REQ'(1) << gnt_idx : '0;
    alu_a = gnt ? req_a[32*gnt_idx +: 32] : '0;
    alu_b = gnt ? req_b[32*gnt_idx +: 32] : '0;
    alu_ctrl = gnt ? req_ctrl[4*gnt_idx +: 4] : 4'b0000;
  end
  // Response register next state; a stalled full register blocks grants so it simply holds
  always_comb begin
    rsp_valid_d = gnt ? S_FULL : (rsp_ready ? S_EMPTY : rsp_valid_q);
    rsp_id_d = gnt ? gnt_idx : rsp_id_q;
    rsp_result_d = gnt ? alu_result : rsp_result_q;
    rsp_zero_d = gnt ? alu_zero : rsp_zero_q;
    rr_ptr_d = gnt ? gnt_idx : rr_ptr_q;
  end
  // Response and priority state; reset hands first priority to requester 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= S_EMPTY;
      rsp_id_q <= '0;
      rsp_result_q <= '0;
      rsp_zero_q <= 1'b0;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q <= rsp_zero_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero = rsp_zero_q;
`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ*16-1:0] perf_grant_q, perf_grant_d;
  logic [15:0]           perf_stall_q, perf_stall_d;
  // Saturating per-requester grant counters and a stall counter
  always_comb begin
    perf_grant_d = perf_grant_q;
    for (int i = 0; i < NUM_REQ; i++)
      perf_grant_d[16*i +: 16] = (gnt && gnt_idx == ID_W'(i) && perf_grant_q[16*i +: 16] != 16'hFFFF) ? perf_grant_q[16*i +: 16] + 16'd1 : perf_grant_q[16*i +: 16];
    perf_stall_d = (|req_valid && !can_issue && perf_stall_q != 16'hFFFF) ? perf_stall_q + 16'd1 : perf_stall_q;
  end
  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_stall_q <= perf_stall_d;
    end
  end
  assign perf_grant_cnt = perf_grant_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule
